// File: rtl/vsfx_pkg.sv
// Shared definitions for the vector byte-shift scheduler slice.
// Holds the operation encodings and the default datapath geometry.
package vsfx_pkg;

  localparam logic [1:0] OP_SLB  = 2'b00;  // shift left, zero fill
  localparam logic [1:0] OP_SRB  = 2'b01;  // logical shift right
  localparam logic [1:0] OP_SRAB = 2'b10;  // arithmetic shift right
  localparam logic [1:0] OP_RLB  = 2'b11;  // rotate left

  localparam int ELEM_W_DEF   = 8;
  localparam int NUM_ELEM_DEF = 4;
  localparam int TAG_W_DEF    = 4;
  localparam int SH_W         = $clog2(ELEM_W_DEF);

endpackage

// File: rtl/vsfx_byte_shifter.sv
// Combinational per-element shifter.
// Ports: op (operation select), vra (source vector), vrb (per-element
// shift amounts, only the low log2(ELEM_W) bits of each element are used),
// vrt (result vector). Element 0 occupies the most significant bits.
module vsfx_byte_shifter
  import vsfx_pkg::*;
#(
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int NUM_ELEM = NUM_ELEM_DEF
) (
  input  logic [1:0]                 op,
  input  logic [ELEM_W*NUM_ELEM-1:0] vra,
  input  logic [ELEM_W*NUM_ELEM-1:0] vrb,
  output logic [ELEM_W*NUM_ELEM-1:0] vrt
);

  localparam int LANE_SH_W = $clog2(ELEM_W);
  localparam int VW        = ELEM_W * NUM_ELEM;

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
    localparam int HI = VW - 1 - i * ELEM_W;
    localparam int LO = HI - ELEM_W + 1;

    logic [ELEM_W-1:0]           a;
    logic [ELEM_W-1:0]           r;
    logic [LANE_SH_W-1:0]        sh;
    logic [ELEM_W-LANE_SH_W-1:0] unused_hi;

    assign a         = vra[HI -: ELEM_W];
    assign sh        = vrb[LO +: LANE_SH_W];
    assign unused_hi = vrb[HI -: (ELEM_W - LANE_SH_W)];

    always_comb begin
      r = a;
      case (op)
        OP_SLB:  r = a << sh;
        OP_SRB:  r = a >> sh;
        OP_SRAB: r = $signed(a) >>> sh;
        // with sh=0 the right-hand term shifts out completely, leaving a
        OP_RLB:  r = (a << sh) | (a >> (ELEM_W - int'(sh)));
      endcase
    end

    assign vrt[HI -: ELEM_W] = r;
  end

endmodule

// File: rtl/vsfx_shift_sched.sv
// Round-robin issue scheduler and two-stage pipeline for the byte-shift
// engine. Two requesters (req0 dispatch, req1 permute/replay) present
// op/vra/vrb/tag with valid/ready; one op per cycle is granted into S1,
// shifted into S2, and returned on res_* with valid/ready backpressure.
// busy reports any occupied pipeline stage.
module vsfx_shift_sched
  import vsfx_pkg::*;
#(
  parameter int ELEM_W   = ELEM_W_DEF,
  parameter int NUM_ELEM = NUM_ELEM_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [1:0]                 req0_op,
  input  logic [ELEM_W*NUM_ELEM-1:0] req0_vra,
  input  logic [ELEM_W*NUM_ELEM-1:0] req0_vrb,
  input  logic [TAG_W-1:0]           req0_tag,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [1:0]                 req1_op,
  input  logic [ELEM_W*NUM_ELEM-1:0] req1_vra,
  input  logic [ELEM_W*NUM_ELEM-1:0] req1_vrb,
  input  logic [TAG_W-1:0]           req1_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ELEM_W*NUM_ELEM-1:0] res_vrt,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_src,
  output logic                       busy
);

  localparam int VW = ELEM_W * NUM_ELEM;

  logic          s1_valid_q, s1_valid_d;
  logic [1:0]    s1_op_q,    s1_op_d;
  logic [VW-1:0] s1_vra_q,   s1_vra_d;
  logic [VW-1:0] s1_vrb_q,   s1_vrb_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic          s1_src_q,   s1_src_d;

  logic          s2_valid_q, s2_valid_d;
  logic [VW-1:0] s2_vrt_q,   s2_vrt_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic          s2_src_q,   s2_src_d;

  // 1 means req1 was granted most recently, so req0 has priority next
  logic          last_grant_q, last_grant_d;

  logic          s2_adv, can_accept, gnt0, gnt1;
  logic [VW-1:0] shift_vrt;

  vsfx_byte_shifter #(
    .ELEM_W   (ELEM_W),
    .NUM_ELEM (NUM_ELEM)
  ) u_shifter (
    .op  (s1_op_q),
    .vra (s1_vra_q),
    .vrb (s1_vrb_q),
    .vrt (shift_vrt)
  );

  always_comb begin
    s2_adv     = !s2_valid_q || res_ready;
    can_accept = !s1_valid_q || s2_adv;
    req0_ready = can_accept && (last_grant_q || !req1_valid);
    req1_ready = can_accept && (!last_grant_q || !req0_valid);
    gnt0       = req0_valid && req0_ready;
    gnt1       = req1_valid && req1_ready;

    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = 1'b1;
    else if (gnt0) last_grant_d = 1'b0;

    // S1 either refills or empties whenever it is free or moving on
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_vra_d   = s1_vra_q;
    s1_vrb_d   = s1_vrb_q;
    s1_tag_d   = s1_tag_q;
    s1_src_d   = s1_src_q;
    if (can_accept) begin
      s1_valid_d = gnt0 || gnt1;
      if (gnt1) begin
        s1_op_d  = req1_op;
        s1_vra_d = req1_vra;
        s1_vrb_d = req1_vrb;
        s1_tag_d = req1_tag;
        s1_src_d = 1'b1;
      end else if (gnt0) begin
        s1_op_d  = req0_op;
        s1_vra_d = req0_vra;
        s1_vrb_d = req0_vrb;
        s1_tag_d = req0_tag;
        s1_src_d = 1'b0;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_vrt_d   = s2_vrt_q;
    s2_tag_d   = s2_tag_q;
    s2_src_d   = s2_src_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_vrt_d = shift_vrt;
        s2_tag_d = s1_tag_q;
        s2_src_d = s1_src_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_vra_q     <= '0;
      s1_vrb_q     <= '0;
      s1_tag_q     <= '0;
      s1_src_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_vrt_q     <= '0;
      s2_tag_q     <= '0;
      s2_src_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_vra_q     <= s1_vra_d;
      s1_vrb_q     <= s1_vrb_d;
      s1_tag_q     <= s1_tag_d;
      s1_src_q     <= s1_src_d;
      s2_valid_q   <= s2_valid_d;
      s2_vrt_q     <= s2_vrt_d;
      s2_tag_q     <= s2_tag_d;
      s2_src_q     <= s2_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_vrt   = s2_vrt_q;
  assign res_tag   = s2_tag_q;
  assign res_src   = s2_src_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_vsfx_shift_sched.sv
// Directed bench for vsfx_shift_sched with a scoreboard of expected results.
module tb_vsfx_shift_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_vra, req0_vrb, req1_vra, req1_vrb;
  logic [3:0]  req0_tag, req1_tag;
  logic        res_valid, res_ready, res_src, busy;
  logic [31:0] res_vrt;
  logic [3:0]  res_tag;

  typedef struct {
    logic [31:0] vrt;
    logic [3:0]  tag;
    logic        src;
  } exp_t;

  exp_t sb[$];
  int   src_log[$];
  int   stamp_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;
  int   acc0;

  vsfx_shift_sched #(.ELEM_W(8), .NUM_ELEM(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_vra(req0_vra), .req0_vrb(req0_vrb), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_vra(req1_vra), .req1_vrb(req1_vrb), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_vrt(res_vrt),
    .res_tag(res_tag), .res_src(res_src), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bit-level reference: each result bit picks its source bit directly.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  av, bv, rv;
    int          sh;
    r = '0;
    for (int e = 0; e < 4; e++) begin
      av = a[31-8*e -: 8];
      bv = b[31-8*e -: 8];
      sh = int'(bv[2:0]);
      for (int j = 0; j < 8; j++) begin
        case (op)
          2'b00:   rv[j] = (j >= sh) ? av[j-sh] : 1'b0;
          2'b01:   rv[j] = (j + sh <= 7) ? av[j+sh] : 1'b0;
          2'b10:   rv[j] = (j + sh <= 7) ? av[j+sh] : av[7];
          default: rv[j] = av[(j - sh + 8) % 8];
        endcase
      end
      r[31-8*e -: 8] = rv;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    @(negedge clk);
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    tick();
  endtask

  task automatic issue(input logic src, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    if (src) begin
      req1_valid = 1'b1; req1_op = op; req1_vra = a; req1_vrb = b; req1_tag = tag;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_vra = a; req0_vrb = b; req0_tag = tag;
    end
    @(negedge clk);
    chk(src ? "req1_ready" : "req0_ready", {63'd0, src ? req1_ready : req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Scoreboard: compare the head whenever a result is visible (also while
  // stalled, so the held value is checked), pop on handshake, push on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("res_unexpected", {63'd0, res_valid}, 64'd0);
        end else begin
          chk("res_vrt", {32'd0, res_vrt}, {32'd0, sb[0].vrt});
          chk("res_tag", {60'd0, res_tag}, {60'd0, sb[0].tag});
          chk("res_src", {63'd0, res_src}, {63'd0, sb[0].src});
          if (res_ready) begin
            void'(sb.pop_front());
            src_log.push_back(int'(res_src));
            stamp_log.push_back(cyc);
          end
        end
      end
      if (req0_valid && req0_ready) begin
        sb.push_back('{vrt: model(req0_op, req0_vra, req0_vrb), tag: req0_tag, src: 1'b0});
        n_acc++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{vrt: model(req1_op, req1_vra, req1_vrb), tag: req1_tag, src: 1'b1});
        n_acc++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_vra = '0; req0_vrb = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = '0; req1_vra = '0; req1_vrb = '0; req1_tag = '0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res_vrt", {32'd0, res_vrt}, 64'd0);
    chk("rst_res_tag", {60'd0, res_tag}, 64'd0);
    chk("rst_res_src", {63'd0, res_src}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    // Latency: driven after edge N, captured at N+1, result after N+2.
    req0_valid = 1'b1; req0_op = 2'b00; req0_vra = 32'h01010101;
    req0_vrb = 32'h01020304; req0_tag = 4'd3;
    @(negedge clk);
    chk("lat_req0_ready", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_early", {63'd0, res_valid}, 64'd0);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    tick();
    @(negedge clk);
    chk("lat_valid", {63'd0, res_valid}, 64'd1);
    chk("lat_vrt_const", {32'd0, res_vrt}, 64'h02040810);
    wait_idle();

    // Back-to-back single-requester grants covering every op.
    issue(1'b0, 2'b00, 32'hffffffff, 32'h08070605, 4'd4);
    issue(1'b0, 2'b00, 32'h0f0f0f0f, 32'h01020408, 4'd5);
    issue(1'b0, 2'b10, 32'h80808080, 32'h01020304, 4'd6);
    issue(1'b0, 2'b11, 32'h81818181, 32'h01010101, 4'd7);
    issue(1'b0, 2'b01, 32'h81818181, 32'h01020304, 4'd8);
    issue(1'b0, 2'b11, 32'h5a3cc3a5, 32'hf8f9fafb, 4'd9);
    wait_idle();

    // req1 path; leaves the pointer favouring req0.
    issue(1'b1, 2'b10, 32'h7f80c301, 32'h07070203, 4'd10);
    wait_idle();

    // Arbitration: both valid for 6 cycles.
    src_log.delete();
    stamp_log.delete();
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1; req0_op = 2'($urandom_range(3)); req0_vra = $urandom;
      req0_vrb = $urandom; req0_tag = 4'(k);
      req1_valid = 1'b1; req1_op = 2'($urandom_range(3)); req1_vra = $urandom;
      req1_vrb = $urandom; req1_tag = 4'(k + 8);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("arb_count", 64'(src_log.size()), 64'd6);
    for (int k = 0; k < src_log.size() && k < 6; k++) begin
      chk("arb_src", 64'(src_log[k]), 64'(k % 2));
      chk("arb_cycle", 64'(stamp_log[k] - stamp_log[0]), 64'(k));
    end

    // Backpressure: two accepts fill S1/S2, then both readies drop.
    res_ready = 1'b0;
    acc0 = n_acc;
    req0_valid = 1'b1; req0_op = 2'b01; req0_vra = 32'hdeadbeef; req0_vrb = 32'h01020304; req0_tag = 4'hA;
    req1_valid = 1'b1; req1_op = 2'b11; req1_vra = 32'h12345678; req1_vrb = 32'h04030201; req1_tag = 4'hB;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("bp_accepted", 64'(n_acc - acc0), 64'd2);
    chk("bp_req0_ready", {63'd0, req0_ready}, 64'd0);
    chk("bp_req1_ready", {63'd0, req1_ready}, 64'd0);
    chk("bp_res_valid", {63'd0, res_valid}, 64'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Reset with S1 and S2 full.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_vra = 32'h11223344; req0_vrb = 32'h01010101; req0_tag = 4'h1;
    req1_valid = 1'b1; req1_op = 2'b01; req1_vra = 32'h55667788; req1_vrb = 32'h02020202; req1_tag = 4'h2;
    tick(); tick();
    @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    src_log.delete();
    @(negedge clk);
    chk("mid_res_valid", {63'd0, res_valid}, 64'd0);
    chk("mid_busy_clr", {63'd0, busy}, 64'd0);
    chk("mid_req0_ready", {63'd0, req0_ready}, 64'd1);
    chk("mid_req1_ready", {63'd0, req1_ready}, 64'd0);
    res_ready = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("mid_count", 64'(src_log.size()), 64'd1);
    if (src_log.size() > 0) chk("mid_first_src", 64'(src_log[0]), 64'd0);
    chk("mid_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vsfx_shift_sched.md
Name: vsfx_shift_sched

Overview:
Issue scheduler and pipeline controller for the vector simple fixed-point byte-shift datapath (vslb family). Two requesters, the dispatch slot and the permute/replay slot, compete for one shared byte-shift engine. A round-robin arbiter grants one operation per cycle into a two-stage registered pipeline, which returns tagged results over a valid/ready handshake with full backpressure.

Parameters:
ELEM_W, 8, element width in bits; shift amount is the low log2(ELEM_W) bits of each vrb element
NUM_ELEM, 4, elements per vector register; vector width VW = ELEM_W*NUM_ELEM = 32
TAG_W, 4, width of the requester-supplied tag returned with the result

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid
req0_op  in  2  00 vslb, 01 vsrb (logical right), 10 vsrab (arithmetic right), 11 vrlb (rotate left)
req0_vra  in  VW  source vector a
req0_vrb  in  VW  per-element shift amounts
req0_tag  in  TAG_W  tag
req1_*  (same set as req0_*)  requester 1
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_vrt  out  VW  result vector
res_tag  out  TAG_W  tag of the completed operation
res_src  out  1  requester index of the completed operation
busy  out  1  any pipeline stage occupied

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: res_valid=0, res_vrt=0, res_tag=0, res_src=0, busy=0. S1 and S2 valid bits are 0. Priority pointer favours req0 first, so last_grant=1.
- Reset asserted mid-operation discards all in-flight operations. No result is produced for them.
- Pipeline:
  - S1 registers the granted op, vra, vrb, tag and src.
  - S2 registers the result computed from S1 through the shifter.
  - res_* is driven directly from S2.
- Latency: a transfer accepted at edge N gives res_valid=1 after edge N+2 when there is no backpressure.
- Throughput: 1 operation/cycle.
- Advance rules:
  - s2_adv = !s2_valid || res_ready.
  - s1_adv = s1_valid && s2_adv.
  - can_accept = !s1_valid || s2_adv.
- Stall: with res_valid=1 and res_ready=0, S2 holds and S1 holds. If both are full, both readies are 0. No data is lost or duplicated.
- Arbitration, round-robin:
  - req0_ready = can_accept && (last_grant==1 || !req1_valid).
  - req1_ready = can_accept && (last_grant==0 || !req0_valid).
  - Neither ready depends on that requester's own valid.
  - last_grant updates only on an actual transfer (valid && ready).
  - A single requester gets back-to-back grants.
- Element math. Each element i is independent, with sh = vrb[i][log2(ELEM_W)-1:0].
  - vslb: a<<sh, zero fill.
  - vsrb: a>>sh, zero fill.
  - vsrab: a>>sh, sign fill.
  - vrlb: rotate left by sh.
  - sh=0 returns a unchanged for all ops.
  - Upper vrb bits are ignored.
- Element 0 is the most significant byte, vrt[VW-1 -: ELEM_W].
- busy = s1_valid || s2_valid.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required for full throughput.

Decomposition:
- Package vsfx_pkg holds:
  - localparams for the op encodings: OP_SLB=2'b00, OP_SRB=2'b01, OP_SRAB=2'b10, OP_RLB=2'b11.
  - ELEM_W and NUM_ELEM defaults.
  - SH_W = $clog2(ELEM_W).
- One sub-module: vsfx_byte_shifter. It is combinational (op, vra, vrb -> vrt), generates NUM_ELEM lanes, and is instantiated once between S1 and S2.
- The arbiter and pipeline control stay in vsfx_shift_sched.

Test Plan:
- vslb, single req0: vra=0x01010101, vrb=0x01020304, tag=3 -> two cycles later res_vrt=0x02040810, res_tag=3, res_src=0.
- vslb wrap, masking high shift bits: vra=0xffffffff, vrb=0x08070605 -> res_vrt=0xff80c0e0. Then vra=0x0f0f0f0f, vrb=0x01020408 -> 0x1e3cf00f.
- vsrab then vrlb:
  - vra=0x80808080, vrb=0x01020304, op=10 -> 0xc0e0f0f8.
  - vra=0x81818181, vrb=0x01010101, op=11 -> 0x03030303.
  - Same vra with op=01 and vrb=0x01020304 -> 0x40201008.
- Arbitration: req0 and req1 held valid for 6 cycles with res_ready=1 -> grants alternate starting with req0. res_src sequence is 0,1,0,1,0,1 with one result per cycle.
- Backpressure: res_ready=0 for 4 cycles with both requesters valid -> exactly 2 ops accepted, then both readies 0. After res_ready=1, results drain in order, none lost or duplicated, and res_vrt is stable while stalled.
- Reset mid-flight: rst_n=0 for one cycle with S1 and S2 full -> next cycle res_valid=0, busy=0. The first grant afterwards goes to req0.
